// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths and shift result record types
package alu_pkg;

    localparam int ALU_WIDTH = 64;
    localparam int ALU_SHW   = 6;
    localparam int ALU_TAGW  = 8;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
    } alu_flags_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        alu_flags_t           flags;
        logic [ALU_TAGW-1:0]  tag;
    } alu_result_t;

endpackage

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - synchronous result FIFO with occupancy count
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = alu_result_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  T                           push_data,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output T                           pop_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    T                mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    // Full and empty come straight from the registered count, so neither
    // handshake input can reach a ready/valid output combinationally.
    assign push_ready = (count != (PW+1)'(DEPTH));
    assign pop_valid  = (count != '0);
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;
    assign pop_data   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_shift_result_stage.sv
// rtl/alu_shift_result_stage.sv - registered sll result stage with flags, tags and FIFO
module alu_shift_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = ALU_SHW,
    parameter int DEPTH = 2,
    parameter int TAGW  = ALU_TAGW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [SHW-1:0]           in_shamt,
    input  logic [WIDTH-1:0]         in_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic                     out_carry,
    output logic [TAGW-1:0]          out_tag,
    output logic [$clog2(DEPTH):0]   count
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        alu_flags_t       flags;
        logic [TAGW-1:0]  tag;
    } entry_t;

    logic [TAGW-1:0] tag_q;
    logic [SHW-1:0]  carry_idx;
    logic            push;
    entry_t          push_entry;
    entry_t          head;

    // The last bit shifted out of a left shift by s is a[WIDTH-s]; modulo
    // WIDTH that index is simply -s in SHW bits.
    assign carry_idx = SHW'(0) - in_shamt;
    assign push      = in_valid && in_ready;

    always_comb begin
        push_entry             = '0;
        push_entry.result      = in_result;
        push_entry.flags.zero  = (in_result == '0);
        push_entry.flags.neg   = in_result[WIDTH-1];
        push_entry.flags.carry = (in_shamt != '0) && in_a[carry_idx];
        push_entry.tag         = tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else if (push) begin
            tag_q <= tag_q + 1'b1;
        end
    end

    alu_result_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (push_entry),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head),
        .count      (count)
    );

    assign out_result = head.result;
    assign out_zero   = head.flags.zero;
    assign out_neg    = head.flags.neg;
    assign out_carry  = head.flags.carry;
    assign out_tag    = head.tag;

endmodule

// File: doc/alu_shift_result_stage.md
# alu_shift_result_stage

Registered result stage directly downstream of the combinational 64-bit `sll` shifter in the ALU datapath. It captures each shift result together with its source operands, computes the zero, negative and carry (last bit shifted out) flags, and tags each result with a sequence number. Results are buffered in a small FIFO behind a valid/ready handshake, so a stalled writeback consumer never drops a shift result.

## Interface
Parameters:
- `WIDTH`, 64: datapath width; must be a power of two.
- `SHW`, 6: shift-amount width; equals log2(`WIDTH`).
- `DEPTH`, 2: result FIFO entries; must be a power of two and at least 2.
- `TAGW`, 8: sequence tag width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  upstream presents a shift operation.
- `in_ready`  out  1  stage can accept an entry this cycle.
- `in_a`  in  `WIDTH`  shifter operand A.
- `in_shamt`  in  `SHW`  shifter shift amount.
- `in_result`  in  `WIDTH`  shifter output (A << shamt).
- `out_valid`  out  1  FIFO head holds a result.
- `out_ready`  in  1  downstream consumes the head.
- `out_result`  out  `WIDTH`  buffered result.
- `out_zero`  out  1  result == 0.
- `out_neg`  out  1  result[`WIDTH`-1].
- `out_carry`  out  1  last bit shifted out.
- `out_tag`  out  `TAGW`  sequence number of the result.
- `count`  out  log2(`DEPTH`)+1  current occupancy.

## Operation
- Push: `in_valid && in_ready`.
  - Writes {in_result, zero, neg, carry, tag} at the write pointer.
  - Increments the write pointer and the tag counter.
- Pop: `out_valid && out_ready`. Increments the read pointer.
- Flags are computed from the inputs at push time and stored with the entry:
  - zero = (in_result == 0).
  - neg = in_result[`WIDTH`-1].
  - carry = 0 if in_shamt == 0; otherwise in_a[`WIDTH` - in_shamt].
- Tag: the first accepted op after reset gets tag 0. Tags then increment by 1 per push and wrap from 2^`TAGW`-1 to 0.
- Pointers are log2(`DEPTH`) bits and wrap naturally at `DEPTH`-1 → 0.
- Occupancy rules:
  - `count` increments on push only, decrements on pop only, and is unchanged on simultaneous push+pop.
  - `in_ready` = (count != `DEPTH`). Full: pushes are blocked, including when a pop happens in the same cycle (no full-bypass).
  - `out_valid` = (count != 0). Empty: no combinational pass-through from input to output.
- `in_valid` deasserted: the input buses are ignored.
- `out_*` data outputs show the head entry whenever `out_valid` = 1. When `out_valid` = 0 they are don't-care, but stable (the last value written at the read pointer).

## Timing
- Latency: an op accepted in cycle N is visible on `out_*` with `out_valid` = 1 in cycle N+1, provided the FIFO was empty.
- Throughput: 1 result/cycle when `out_ready` is held at 1.
- `in_ready`, `out_valid` and `count` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Reset (asynchronous assert, synchronous-to-`clk` deassert handled upstream):
  - count = 0, pointers = 0, tag = 0.
  - `out_valid` = 0, `in_ready` = 1.
  - `out_result` = 0 and all flags = 0 (storage cleared).
- Reset mid-operation: all buffered entries are discarded. The first push after reset gets tag 0.

## Structure
- Shared package `alu_pkg` holds:
  - `ALU_WIDTH` = 64 and `ALU_SHW` = 6.
  - typedef `alu_flags_t` = packed struct {zero, neg, carry}.
  - typedef `alu_result_t` = {result, flags, tag}.
- Sub-module `alu_result_fifo`: parameterised synchronous FIFO of `alu_result_t`, with pointers, count and the full/empty decode.
- The top level contains the flag computation, the tag counter and the FIFO instance.

## Test plan
- Reset, then A=0xFF, shamt=8, result=0xFF00, hold `out_ready`=1 → next cycle `out_valid`=1, result 0xFF00, Z=0, N=0, C=0, tag 0.
- A=0xFFFFFFFF00000000, shamt=32, result=0 → Z=1, N=0, C=1 (A[32]).
- A=1, shamt=63, result=0x8000000000000000 → N=1, C=A[1]=0.
- Same case with shamt=0 → C=0.
- Hold `out_ready`=0 and drive 3 valid ops:
  - First two accepted; `in_ready` drops with count=2; the third is held.
  - Raise `out_ready`: order preserved, tags 0,1,2.
  - The third op is accepted only one cycle after the first pop.
- 300 back-to-back pushes with `out_ready`=1 → tags wrap 255→0; count stays ≤1.
- Assert `rst_n`=0 with count=2 → `out_valid`=0 and `in_ready`=1 immediately. The next accepted op gets tag 0.
